// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the 101101 serial pattern detector.
package sequence_detector_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4,  // "1011"
    S5 = 3'd5,  // "10110"
    S6 = 3'd6   // "101101", Moore machine only
  } state_t;

  localparam logic [5:0] PATTERN     = 6'b101101;
  localparam int         PATTERN_LEN = 6;

endpackage

// File: rtl/sequence_detector_101101.sv
// Mealy and Moore detectors for 101101 running side by side, plus a saturating match counter.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; otherwise detection is non-overlapping.
module sequence_detector_101101
  import sequence_detector_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             mealy_out,
  output logic             moore_out,
  output logic [CNT_W-1:0] match_cnt
);

  state_t mealy_state;
  state_t moore_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mealy_state <= S0;
    end else begin
      case (mealy_state)
        S0: mealy_state <= in ? S1 : S0;
        S1: mealy_state <= in ? S1 : S2;
        S2: mealy_state <= in ? S3 : S0;
        S3: mealy_state <= in ? S4 : S2;
        S4: mealy_state <= in ? S1 : S5;
        S5: begin
`ifdef SEQ_DET_OVERLAP_EN
          mealy_state <= in ? S3 : S0;
`else
          mealy_state <= S0;
`endif
        end
        default: mealy_state <= S0;  // S6 and 3'b111 are unreachable here
      endcase
    end
  end

  assign mealy_out = (mealy_state == S5) && in;

  // moore_out is registered alongside the state so it is high exactly while the state is S6.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moore_state <= S0;
      moore_out   <= 1'b0;
    end else begin
      moore_out <= 1'b0;
      case (moore_state)
        S0: moore_state <= in ? S1 : S0;
        S1: moore_state <= in ? S1 : S2;
        S2: moore_state <= in ? S3 : S0;
        S3: moore_state <= in ? S4 : S2;
        S4: moore_state <= in ? S1 : S5;
        S5: begin
          if (in) begin
            moore_state <= S6;
            moore_out   <= 1'b1;
          end else begin
            moore_state <= S0;
          end
        end
        S6: begin
`ifdef SEQ_DET_OVERLAP_EN
          moore_state <= in ? S4 : S2;
`else
          moore_state <= in ? S1 : S0;
`endif
        end
        default: moore_state <= S0;
      endcase
    end
  end

  // NOTE: the counter is a plain register with an async reset; no memory is involved, so resetting it is cheap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (mealy_out && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sequence_detector_101101.sv
// Self-checking bench: directed scenarios plus random streams against a window-based reference model.
module tb_sequence_detector_101101;

  localparam logic [5:0] PAT = 6'b101101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic       mealy_out, moore_out;
  logic [7:0] match_cnt;
  logic       mealy_out_n, moore_out_n;
  logic [1:0] match_cnt_n;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: bits seen since reset (or since the last match in non-overlap mode).
  bit          hist[$];
  int unsigned cnt8_exp = 0;
  int unsigned cnt2_exp = 0;
  logic        moore_exp = 1'b0;

  sequence_detector_101101 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in),
    .mealy_out(mealy_out), .moore_out(moore_out), .match_cnt(match_cnt)
  );

  sequence_detector_101101 #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .in(in),
    .mealy_out(mealy_out_n), .moore_out(moore_out_n), .match_cnt(match_cnt_n)
  );

  always #5 clk = ~clk;

  function automatic logic would_match(input logic b);
    logic [5:0] w;
    int n;
    n = hist.size();
    if (n < 5) return 1'b0;
    for (int i = 0; i < 5; i++) w[5-i] = hist[n-5+i];
    w[0] = b;
    return (w == PAT);
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt8_exp  = 0;
    cnt2_exp  = 0;
    moore_exp = 1'b0;
  endtask

  // Called in the low clock phase: drive a bit, compare outputs, then advance past the edge.
  task automatic apply_bit(input logic b, input string tag);
    logic m;
    in = b;
    #1;
    m = would_match(b);
    total_cnt += 4;
    if (mealy_out !== m)
      $display("FAIL %s mealy_out: got %b want %b", tag, mealy_out, m);
    else pass_cnt++;
    if (moore_out !== moore_exp)
      $display("FAIL %s moore_out: got %b want %b", tag, moore_out, moore_exp);
    else pass_cnt++;
    if (match_cnt !== 8'(cnt8_exp))
      $display("FAIL %s match_cnt: got %0d want %0d", tag, match_cnt, cnt8_exp);
    else pass_cnt++;
    if (match_cnt_n !== 2'(cnt2_exp))
      $display("FAIL %s match_cnt narrow: got %0d want %0d", tag, match_cnt_n, cnt2_exp);
    else pass_cnt++;
    @(posedge clk);
    hist.push_back(b);
    if (hist.size() > 6) void'(hist.pop_front());
    if (m) begin
      if (cnt8_exp < 255) cnt8_exp++;
      if (cnt2_exp < 3) cnt2_exp++;
`ifndef SEQ_DET_OVERLAP_EN
      hist.delete();
`endif
    end
    moore_exp = m;
  endtask

  task automatic drive_bit(input logic b, input string tag);
    @(negedge clk);
    apply_bit(b, tag);
  endtask

  task automatic drive_seq(input logic [31:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) drive_bit(bits[i], tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in  = 1'b1;
    #12;
    total_cnt += 3;
    if (mealy_out !== 1'b0) $display("FAIL reset mealy_out: got %b want 0", mealy_out);
    else pass_cnt++;
    if (moore_out !== 1'b0) $display("FAIL reset moore_out: got %b want 0", moore_out);
    else pass_cnt++;
    if (match_cnt !== 8'd0) $display("FAIL reset match_cnt: got %0d want 0", match_cnt);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed_overlap();
    do_reset();
    drive_seq(32'b0000, 4, "idle");
    drive_seq(32'b101101101, 9, "directed");
    drive_bit(1'b0, "directed_tail");
    total_cnt++;
`ifdef SEQ_DET_OVERLAP_EN
    if (match_cnt !== 8'd2) $display("FAIL directed count: got %0d want 2", match_cnt);
    else pass_cnt++;
`else
    if (match_cnt !== 8'd1) $display("FAIL directed count: got %0d want 1", match_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_leading_ones();
    do_reset();
    drive_seq(32'b111101101, 9, "ones");
    drive_bit(1'b0, "ones_tail");
    drive_bit(1'b0, "ones_tail2");
    total_cnt++;
    if (match_cnt !== 8'd1) $display("FAIL ones count: got %0d want 1", match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_s3_fallback();
    do_reset();
    drive_seq(32'b10101101, 8, "s3_fallback");
    drive_bit(1'b0, "s3_tail");
    total_cnt++;
    if (match_cnt !== 8'd1) $display("FAIL s3_fallback count: got %0d want 1", match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    drive_seq(32'b10110, 5, "pre_reset");
    @(negedge clk);
    in  = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt += 3;
    if (mealy_out !== 1'b0) $display("FAIL midreset mealy_out: got %b want 0", mealy_out);
    else pass_cnt++;
    if (moore_out !== 1'b0) $display("FAIL midreset moore_out: got %b want 0", moore_out);
    else pass_cnt++;
    if (match_cnt !== 8'd0) $display("FAIL midreset match_cnt: got %0d want 0", match_cnt);
    else pass_cnt++;
    model_reset();
    #1;
    rst = 1'b1;
    apply_bit(1'b1, "post_reset");
    drive_bit(1'b0, "post_reset2");
    total_cnt++;
    if (match_cnt !== 8'd0) $display("FAIL post_reset count: got %0d want 0", match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int unsigned want[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_seq(32'b10110100, 8, "sat");
      total_cnt++;
      if (match_cnt_n !== 2'(want[k]))
        $display("FAIL saturation pattern %0d: got %0d want %0d", k, match_cnt_n, want[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_comb_toggle();
    do_reset();
    drive_seq(32'b10110, 5, "toggle_pre");
    @(negedge clk);
    in = 1'b0;
    #1;
    total_cnt++;
    if (mealy_out !== 1'b0) $display("FAIL toggle low1: got %b want 0", mealy_out);
    else pass_cnt++;
    in = 1'b1;
    #1;
    total_cnt++;
    if (mealy_out !== 1'b1) $display("FAIL toggle high: got %b want 1", mealy_out);
    else pass_cnt++;
    in = 1'b0;
    #1;
    total_cnt++;
    if (mealy_out !== 1'b0) $display("FAIL toggle low2: got %b want 0", mealy_out);
    else pass_cnt++;
    apply_bit(1'b1, "toggle_final");
    drive_bit(1'b0, "toggle_tail");
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) drive_seq(32'b101101, 6, "rand_pat");
      else for (int j = 0; j < 6; j++) drive_bit(1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed_overlap();
    test_leading_ones();
    test_s3_fallback();
    test_reset_mid_sequence();
    test_saturation();
    test_comb_toggle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sequence_detector_101101.md
# sequence_detector_101101

Serial pattern detector that recognises the bit sequence 1-0-1-1-0-1 (MSB first, one bit per clock) on a single-bit input stream. It runs a Mealy machine and a Moore machine side by side on the same input, giving an immediate combinational flag and a registered, one-cycle-later flag. A saturating match counter is included for status readback. The block sits directly on a serial data line, feeding control or monitoring logic.

## Interface
- CNT_W, 8: width of the match counter, minimum 1.
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  one clock; reset is asynchronous and active-low.
- in  input  1  serial data bit, sampled on each rising clk edge.
- mealy_out  output  1  combinational match flag from the Mealy machine.
- moore_out  output  1  registered match flag from the Moore machine.
- match_cnt  output  CNT_W  count of Mealy matches since reset; saturates at all-ones.

## Operation
- Overlapping detection when SEQ_DET_OVERLAP_EN is defined; see Configuration.
- Mealy states: S0 idle, S1 "1", S2 "10", S3 "101", S4 "1011", S5 "10110".
- Mealy transitions as in=0 / in=1:
  - S0: S0 / S1.
  - S1: S2 / S1.
  - S2: S0 / S3.
  - S3: S2 / S4.
  - S4: S5 / S1.
  - S5: S0 / S3 with a match.
- mealy_out = (state==S5) && in. No other condition drives it.
- Moore states: S0 to S5 as above, plus S6 "101101".
- Moore transitions equal the Mealy ones, except S5 with in=1 goes to S6.
- S6 transitions: in=0 to S2, in=1 to S4.
- moore_out = (state==S6).
- match_cnt increments by 1 on each rising edge where mealy_out=1. It holds at 2^CNT_W-1 once it reaches that value; it never wraps.
- Unreachable state encodings return to S0 on the next edge. Outputs are 0 while in such an encoding.

## Timing
- Reset, asynchronous on rst=0: both state registers go to S0 and match_cnt to 0. moore_out=0 and mealy_out=0, the latter because the state is S0.
- Reset release is synchronous to clk. The first bit sampled is the one present at the first rising edge with rst=1.
- Mealy latency is 0 cycles. mealy_out is high during the cycle in which the 6th bit is present on in, and the state registers that bit at the closing edge.
- Moore latency is 1 cycle. moore_out is high for exactly the one cycle after the edge that sampled the 6th bit.
- match_cnt updates at the same edge that samples the 6th bit.
- Reset asserted mid-sequence discards all partial progress. A sequence straddling the reset is never reported.
- Back-to-back overlapping matches are 3 bits apart at minimum, e.g. 101101101. Neither output holds high across consecutive matches.

## Configuration
- SEQ_DET_OVERLAP_EN defined, which is the default build: overlapping detection as specified above.
- SEQ_DET_OVERLAP_EN undefined: non-overlapping detection.
  - Mealy S5 with in=1 goes to S0.
  - Moore S6 goes to S0 on in=0 and to S1 on in=1.
  - All other behaviour is unchanged.

## Structure
- A shared package sequence_detector_pkg holds:
  - the state enum typedef (S0 to S6, 3-bit encoding);
  - the pattern constant 6'b101101;
  - the pattern length constant 6.
- Both machines and the counter are independent processes in the single module. A sub-module is not warranted.

## Test plan
- Directed stimulus: reset, then idle zeros, then 1,0,1,1,0,1,1,0,1.
  - mealy_out pulses on bits 6 and 9, moore_out one cycle after each.
  - match_cnt=2 with SEQ_DET_OVERLAP_EN.
  - Without the macro: a single pulse on bit 6 and match_cnt=1.
- Stream 1,1,1,1,0,1,1,0,1 → single match on bit 9, moore_out high in the following cycle only.
- Stream 1,0,1,0,1,1,0,1 → S3 to S2 on the 0, one match on bit 8. No false match on bit 6.
- Drive 1,0,1,1,0, assert rst=0 mid-cycle, release it, then drive 1. Required response:
  - mealy_out and moore_out stay 0;
  - match_cnt=0.
- CNT_W=2, five non-overlapping 101101 patterns → match_cnt reads 1,2,3,3,3.
- In S5, toggle in 0→1→0 between edges → mealy_out follows in combinationally; state unaffected until the edge.
